// File: rtl/pia_input_scanner.sv
// Purpose: scans a 16-bit 74HC165-style controller shift register, debounces it, and drives the PIA buttons/sw inputs plus a presence flag.
// Latency: a frame spans 2*CLK_HALF + CLK_HALF + 15*2*CLK_HALF + 1 cycles from latch rise; outputs update on the edge after frame_o.
// Backpressure: none; scan_en_i only gates new frames, and a frame already in flight always runs to completion.
module pia_input_scanner #(
    parameter int CLK_HALF    = 4,
    parameter int SCAN_PERIOD = 16384,
    parameter int DEB_SCANS   = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scan_en_i,
    input  logic       pad_dat_i,
    output logic       pad_latch_o,
    output logic       pad_clk_o,
    output logic [6:0] buttons,
    output logic [3:0] sw,
    output logic       present_o,
    output logic       frame_o
);

    localparam int PW  = $clog2(SCAN_PERIOD);
    localparam int PHW = $clog2(2 * CLK_HALF);
    localparam logic [PW-1:0]  PER_LAST   = PW'(SCAN_PERIOD - 1);
    localparam logic [PHW-1:0] LATCH_LAST = PHW'(2 * CLK_HALF - 1);
    localparam logic [PHW-1:0] HALF_LAST  = PHW'(CLK_HALF - 1);
    localparam logic [3:0]     DEB_LAST   = 4'(DEB_SCANS - 1);
    // Marker bits 15..11, sample order 11 first: 1,0,1,0,0.
    localparam logic [4:0]     MARKER     = 5'b00101;
    localparam logic [10:0]    DATA_RST   = {4'h0, 7'h7F};

    typedef enum logic [2:0] {
        IDLE, LATCH, SETTLE, SHIFT_HI, SHIFT_LO, EVAL
    } state_t;

    logic [1:0]        rst_sync_q;
    logic              rst_n_int;
    logic [1:0]        dat_sync_q;
    logic [PW-1:0]     per_q, per_d;
    logic              tick;
    state_t            state_q, state_d;
    logic [PHW-1:0]    ph_q, ph_d;
    logic [3:0]        bit_q, bit_d;
    logic [15:0]       frame_q, frame_d;
    logic [10:0]       data_q, data_d;
    logic [10:0][3:0]  cnt_q, cnt_d;
    logic              present_q, present_d;

    // Reset asserts asynchronously but releases in step with clk_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    // Two-flop synchronizer for the asynchronous serial pad.
    always_ff @(posedge clk_i or negedge rst_n_int) begin
        if (!rst_n_int) dat_sync_q <= 2'b00;
        else            dat_sync_q <= {dat_sync_q[0], pad_dat_i};
    end

    assign tick  = (per_q == PER_LAST);
    assign per_d = tick ? '0 : per_q + 1'b1;

    // Frame sequencer next state: phase timing, bit index and sample capture.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        case (state_q)
            IDLE: begin
                ph_d = '0;
                if (tick && scan_en_i) begin
                    state_d = LATCH;
                    bit_d   = '0;
                end
            end
            LATCH: begin
                if (ph_q == LATCH_LAST) begin
                    ph_d    = '0;
                    state_d = SETTLE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            SETTLE: begin
                if (ph_q == HALF_LAST) begin
                    ph_d       = '0;
                    frame_d[0] = dat_sync_q[1];
                    bit_d      = '0;
                    state_d    = SHIFT_HI;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (ph_q == HALF_LAST) begin
                    ph_d    = '0;
                    state_d = SHIFT_LO;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            SHIFT_LO: begin
                if (ph_q == HALF_LAST) begin
                    ph_d                    = '0;
                    frame_d[bit_q + 4'd1]   = dat_sync_q[1];
                    bit_d                   = bit_q + 4'd1;
                    state_d                 = (bit_q == 4'd14) ? EVAL : SHIFT_HI;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            EVAL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame evaluation: marker check, per-bit debounce, release-all on a bad frame.
    always_comb begin
        data_d    = data_q;
        cnt_d     = cnt_q;
        present_d = present_q;
        if (state_q == EVAL) begin
            if (frame_q[15:11] == MARKER) begin
                present_d = 1'b1;
                for (int i = 0; i < 11; i++) begin
                    if (frame_q[i] == data_q[i]) begin
                        cnt_d[i] = 4'd0;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        data_d[i] = frame_q[i];
                        cnt_d[i]  = 4'd0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 4'd1;
                    end
                end
            end else begin
                present_d   = 1'b0;
                data_d[6:0] = 7'h7F;
                for (int i = 0; i < 7; i++) begin
                    cnt_d[i] = 4'd0;
                end
            end
        end
    end

    // State registers; reset aborts any frame in flight without touching outputs beyond their reset values.
    always_ff @(posedge clk_i or negedge rst_n_int) begin
        if (!rst_n_int) begin
            per_q     <= '0;
            state_q   <= IDLE;
            ph_q      <= '0;
            bit_q     <= '0;
            frame_q   <= '0;
            data_q    <= DATA_RST;
            cnt_q     <= '0;
            present_q <= 1'b0;
        end else begin
            per_q     <= per_d;
            state_q   <= state_d;
            ph_q      <= ph_d;
            bit_q     <= bit_d;
            frame_q   <= frame_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            present_q <= present_d;
        end
    end

    assign pad_latch_o = (state_q == LATCH);
    assign pad_clk_o   = (state_q == SHIFT_HI);
    assign frame_o     = (state_q == EVAL);
    assign buttons     = data_q[6:0];
    assign sw          = data_q[10:7];
    assign present_o   = present_q;

endmodule

// File: tb/tb_pia_input_scanner.sv
// Bench for pia_input_scanner: a behavioural 74HC165 model feeds table-driven frames,
// plus directed sequences for reset abort, pad waveform timing and scan enable gating.
module tb_pia_input_scanner;

    localparam int CH  = 4;
    localparam int SP  = 200;
    localparam int DEB = 3;
    localparam logic [4:0] GOOD = 5'b00101;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       scan_en;
    logic       pad_dat;
    logic       pad_latch_o;
    logic       pad_clk_o;
    logic [6:0] buttons;
    logic [3:0] sw;
    logic       present_o;
    logic       frame_o;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [15:0] model_frame = 16'hFFFF;
    logic [15:0] model_sr    = 16'hFFFF;

    pia_input_scanner #(.CLK_HALF(CH), .SCAN_PERIOD(SP), .DEB_SCANS(DEB)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .scan_en_i  (scan_en),
        .pad_dat_i  (pad_dat),
        .pad_latch_o(pad_latch_o),
        .pad_clk_o  (pad_clk_o),
        .buttons    (buttons),
        .sw         (sw),
        .present_o  (present_o),
        .frame_o    (frame_o)
    );

    always #5 clk = ~clk;

    // Shift register model: parallel load while latch is high, shift toward bit 0 on pad clock rise.
    always @(posedge pad_latch_o or posedge pad_clk_o) begin
        if (pad_latch_o) model_sr <= model_frame;
        else             model_sr <= {1'b1, model_sr[15:1]};
    end
    assign pad_dat = model_sr[0];

    // Cycles since reset release, counted on rising edges.
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    typedef struct {
        logic [15:0] frame;
        logic [6:0]  exp_btn;
        logic [3:0]  exp_sw;
        logic        exp_pres;
    } vec_t;

    vec_t vecs[24];

    function automatic logic [15:0] mk(logic [6:0] b, logic [3:0] s, logic [4:0] m);
        return {m, s, b};
    endfunction

    function automatic vec_t mkv(logic [15:0] f, logic [6:0] b, logic [3:0] s, logic p);
        vec_t v;
        v.frame = f; v.exp_btn = b; v.exp_sw = s; v.exp_pres = p;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns at the falling edge where frame_o is first seen high.
    task automatic wait_frame_o(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 2 * SP + 300; n++) begin
            @(negedge clk);
            if (frame_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Returns at the falling edge where pad_latch_o is first seen rising.
    task automatic wait_latch_rise(output int at_cyc, output bit ok);
        logic prev;
        prev   = pad_latch_o;
        ok     = 1'b0;
        at_cyc = 0;
        for (int n = 0; n < 2 * SP + 300; n++) begin
            @(negedge clk);
            if (pad_latch_o && !prev) begin
                ok     = 1'b1;
                at_cyc = cyc;
                break;
            end
            prev = pad_latch_o;
        end
    endtask

    task automatic wait_pad_rises(input int count, output bit ok);
        logic prev;
        int   seen;
        prev = pad_clk_o;
        seen = 0;
        ok   = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (pad_clk_o && !prev) seen++;
            prev = pad_clk_o;
            if (seen == count) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_frame(string tag, logic [15:0] f, logic [6:0] eb, logic [3:0] es, logic ep);
        bit ok;
        model_frame = f;
        wait_frame_o(ok);
        chk({tag, "_frame_seen"}, 32'(ok), 32'd1);
        @(negedge clk);
        chk({tag, "_buttons"}, 32'(buttons), 32'(eb));
        chk({tag, "_sw"}, 32'(sw), 32'(es));
        chk({tag, "_present"}, 32'(present_o), 32'(ep));
        chk({tag, "_frame_one_cycle"}, 32'(frame_o), 32'd0);
    endtask

    task automatic measure_frame();
        int   t0, lat, rises, run, rmin, rmax, fcnt, len;
        bit   ok;
        logic pc_prev;
        lat = 0; rises = 0; run = 0; rmin = 999; rmax = 0; fcnt = 0; len = 0;
        pc_prev = 1'b0;
        wait_latch_rise(t0, ok);
        chk("wave_latch_seen", 32'(ok), 32'd1);
        for (int n = 1; n <= 300; n++) begin
            if (n > 1) @(negedge clk);
            if (pad_latch_o) lat++;
            if (pad_clk_o) begin
                if (!pc_prev) rises++;
                run++;
            end else if (pc_prev) begin
                if (run < rmin) rmin = run;
                if (run > rmax) rmax = run;
                run = 0;
            end
            pc_prev = pad_clk_o;
            if (frame_o) begin
                fcnt++;
                len = n;
                break;
            end
        end
        @(negedge clk);
        if (frame_o) fcnt++;
        chk("wave_latch_cycles", 32'(lat), 32'(2 * CH));
        chk("wave_clk_rises", 32'(rises), 32'd15);
        chk("wave_clk_high_min", 32'(rmin), 32'(CH));
        chk("wave_clk_high_max", 32'(rmax), 32'(CH));
        chk("wave_frame_len", 32'(len), 32'(2 * CH + CH + 15 * 2 * CH + 1));
        chk("wave_frame_pulses", 32'(fcnt), 32'd1);
    endtask

    initial begin
        bit ok;
        int t, en_cyc, latches;

        // Frame table: expected outputs after each frame with DEB_SCANS=3.
        vecs[0]  = mkv(mk(7'h7D, 4'h5, GOOD), 7'h7F, 4'h0, 1'b1);
        vecs[1]  = mkv(mk(7'h7D, 4'h5, GOOD), 7'h7F, 4'h0, 1'b1);
        vecs[2]  = mkv(mk(7'h7D, 4'h5, GOOD), 7'h7D, 4'h5, 1'b1);
        vecs[3]  = mkv(mk(7'h7F, 4'h5, GOOD), 7'h7D, 4'h5, 1'b1);
        vecs[4]  = mkv(mk(7'h7F, 4'h5, GOOD), 7'h7D, 4'h5, 1'b1);
        vecs[5]  = mkv(mk(7'h7F, 4'h5, GOOD), 7'h7F, 4'h5, 1'b1);
        vecs[6]  = mkv(mk(7'h7D, 4'h5, GOOD), 7'h7F, 4'h5, 1'b1);
        vecs[7]  = mkv(mk(7'h7D, 4'h5, GOOD), 7'h7F, 4'h5, 1'b1);
        vecs[8]  = mkv(mk(7'h7F, 4'h5, GOOD), 7'h7F, 4'h5, 1'b1);
        vecs[9]  = mkv(mk(7'h7D, 4'h5, GOOD), 7'h7F, 4'h5, 1'b1);
        vecs[10] = mkv(mk(7'h7D, 4'h5, GOOD), 7'h7F, 4'h5, 1'b1);
        vecs[11] = mkv(mk(7'h7D, 4'h5, GOOD), 7'h7D, 4'h5, 1'b1);
        vecs[12] = mkv(mk(7'h77, 4'h5, GOOD), 7'h7D, 4'h5, 1'b1);
        vecs[13] = mkv(mk(7'h77, 4'h5, GOOD), 7'h7D, 4'h5, 1'b1);
        vecs[14] = mkv(mk(7'h77, 4'h5, GOOD), 7'h77, 4'h5, 1'b1);
        vecs[15] = mkv(16'hFFFF,              7'h7F, 4'h5, 1'b0);
        vecs[16] = mkv(mk(7'h77, 4'h5, GOOD), 7'h7F, 4'h5, 1'b1);
        vecs[17] = mkv(mk(7'h77, 4'h5, GOOD), 7'h7F, 4'h5, 1'b1);
        vecs[18] = mkv(mk(7'h77, 4'h5, GOOD), 7'h77, 4'h5, 1'b1);
        vecs[19] = mkv(mk(7'h77, 4'h5, 5'b10101), 7'h7F, 4'h5, 1'b0);
        vecs[20] = mkv(16'h0000,              7'h7F, 4'h5, 1'b0);
        vecs[21] = mkv(mk(7'h77, 4'hA, GOOD), 7'h7F, 4'h5, 1'b1);
        vecs[22] = mkv(mk(7'h77, 4'hA, GOOD), 7'h7F, 4'h5, 1'b1);
        vecs[23] = mkv(mk(7'h77, 4'hA, GOOD), 7'h77, 4'hA, 1'b1);

        rst_ni      = 1'b0;
        scan_en     = 1'b1;
        model_frame = mk(7'h00, 4'hF, GOOD);
        repeat (3) @(negedge clk);
        chk("rst_buttons", 32'(buttons), 32'h7F);
        chk("rst_sw", 32'(sw), 32'h0);
        chk("rst_present", 32'(present_o), 32'd0);
        chk("rst_frame", 32'(frame_o), 32'd0);
        chk("rst_latch", 32'(pad_latch_o), 32'd0);
        chk("rst_padclk", 32'(pad_clk_o), 32'd0);
        #1 rst_ni = 1'b1;

        // All buttons pressed, switches all on: settles after three frames.
        run_frame("allp1", mk(7'h00, 4'hF, GOOD), 7'h7F, 4'h0, 1'b1);
        run_frame("allp2", mk(7'h00, 4'hF, GOOD), 7'h7F, 4'h0, 1'b1);
        run_frame("allp3", mk(7'h00, 4'hF, GOOD), 7'h00, 4'hF, 1'b1);

        // Reset during bit 7 of the next frame aborts it and restores reset outputs at once.
        wait_latch_rise(t, ok);
        chk("midrst_latch_seen", 32'(ok), 32'd1);
        wait_pad_rises(7, ok);
        chk("midrst_bit7_seen", 32'(ok), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst_buttons", 32'(buttons), 32'h7F);
        chk("midrst_sw", 32'(sw), 32'h0);
        chk("midrst_present", 32'(present_o), 32'd0);
        chk("midrst_padclk", 32'(pad_clk_o), 32'd0);
        chk("midrst_latch", 32'(pad_latch_o), 32'd0);
        repeat (3) @(negedge clk);
        model_frame = vecs[0].frame;
        #1 rst_ni = 1'b1;
        // Two cycles of reset release synchronization, then SP-1 counts to the tick, then LATCH.
        wait_latch_rise(t, ok);
        chk("midrst_relatch_seen", 32'(ok), 32'd1);
        chk("midrst_first_latch_cyc", 32'(t), 32'(SP + 2));

        foreach (vecs[i]) begin
            run_frame($sformatf("vec%0d", i), vecs[i].frame, vecs[i].exp_btn, vecs[i].exp_sw, vecs[i].exp_pres);
        end

        measure_frame();

        // Drop scan enable mid-frame: that frame finishes, then scanning stops until re-enabled.
        wait_latch_rise(t, ok);
        chk("scanen_latch_seen", 32'(ok), 32'd1);
        wait_pad_rises(3, ok);
        chk("scanen_bit3_seen", 32'(ok), 32'd1);
        #1 scan_en = 1'b0;
        wait_frame_o(ok);
        chk("scanen_frame_completes", 32'(ok), 32'd1);
        latches = 0;
        for (int n = 0; n < 3 * SP; n++) begin
            @(negedge clk);
            if (pad_latch_o) latches++;
        end
        chk("scanen_no_latch", 32'(latches), 32'd0);
        chk("scanen_hold_buttons", 32'(buttons), 32'h77);
        chk("scanen_hold_sw", 32'(sw), 32'hA);
        #1 scan_en = 1'b1;
        en_cyc = cyc;
        wait_latch_rise(t, ok);
        chk("scanen_resume_seen", 32'(ok), 32'd1);
        chk("scanen_resume_within_period", 32'(t - en_cyc <= SP + 1), 32'd1);
        chk("scanen_resume_on_tick", 32'((t - 2) % SP), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
